// File: rtl/load_cntrl.sv
// MEM-stage load controller: issues a word-aligned read and waits for the response.
// It then returns the byte/half/word, sign- or zero-extended, and stalls the pipeline meanwhile.
module load_cntrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  input  logic [2:0]      load_type_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic            kill_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            stall_o,
  output logic            load_valid_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            misalign_o,
  output logic            bus_err_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] cnt, cnt_nxt;
  logic [2:0]      ltype;
  logic [1:0]      off;
  logic            legal, accept, misalign_nxt, bus_err_nxt, expired;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] extracted;

  always_comb begin
    case (load_type_i)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~addr_i[0];
      3'b010:         legal = (addr_i[1:0] == 2'b00);
      default:        legal = 1'b0;
    endcase
  end

  assign accept  = (state == IDLE) && req_valid_i && !kill_i && legal;
  assign expired = (cnt == TO_W'(TIMEOUT - 1));

  assign byte_sel = mem_rdata_i[8*off +: 8];
  assign half_sel = mem_rdata_i[16*off[1] +: 16];

  always_comb begin
    case (ltype)
      3'b000:  extracted = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b100:  extracted = {{(XLEN-8){1'b0}}, byte_sel};
      3'b001:  extracted = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b101:  extracted = {{(XLEN-16){1'b0}}, half_sel};
      default: extracted = mem_rdata_i;
    endcase
  end

  // Kill wins over gnt/rvalid; a killed load still waiting for data drains its response.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    misalign_nxt = 1'b0;
    bus_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = REQ;
        else if (req_valid_i && !kill_i) misalign_nxt = 1'b1;
      end
      REQ: begin
        if (kill_i) state_nxt = IDLE;
        else if (mem_gnt_i) begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
      end
      WAIT: begin
        if (kill_i && mem_rvalid_i) state_nxt = IDLE;
        else if (kill_i) begin
          state_nxt = DRAIN;
          cnt_nxt   = cnt + 1'b1;
        end else if (mem_rvalid_i) state_nxt = DONE;
        else if (expired) begin
          state_nxt   = IDLE;
          bus_err_nxt = 1'b1;
        end else cnt_nxt = cnt + 1'b1;
      end
      DONE: state_nxt = IDLE;
      DRAIN: begin
        if (mem_rvalid_i || expired) state_nxt = IDLE;
        else cnt_nxt = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      ltype       <= '0;
      off         <= '0;
      mem_addr_o  <= '0;
      load_data_o <= '0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      misalign_o <= misalign_nxt;
      bus_err_o  <= bus_err_nxt;
      if (accept) begin
        ltype      <= load_type_i;
        off        <= addr_i[1:0];
        mem_addr_o <= {addr_i[XLEN-1:2], 2'b00};
      end
      if (state == WAIT && mem_rvalid_i && !kill_i) load_data_o <= extracted;
    end
  end

  assign mem_req_o    = (state == REQ);
  assign load_valid_o = (state == DONE);
  assign stall_o      = (state == REQ) || (state == WAIT) || (state == DRAIN) || accept;

endmodule

// File: tb/tb_load_cntrl.sv
// Directed bench for load_cntrl: output events are scoreboarded with their expected cycle;
// combinational and registered outputs are checked with immediate assertions.
module tb_load_cntrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [2:0]  load_type;
  logic [31:0] addr;
  logic        kill;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misalign;
  logic        bus_err;

  typedef struct {
    logic [2:0]  mask;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  localparam logic [2:0] EV_LOAD = 3'b100;
  localparam logic [2:0] EV_MIS  = 3'b010;
  localparam logic [2:0] EV_BUS  = 3'b001;

  ev_t         sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_data = '0;

  load_cntrl #(.XLEN(32), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .load_type_i(load_type),
    .addr_i(addr), .kill_i(kill), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .stall_o(stall), .load_valid_o(load_valid), .load_data_o(load_data),
    .misalign_o(misalign), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; registered pulses are then matched against the scoreboard head.
  task automatic tick();
    ev_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("event_kind", {29'b0, load_valid, misalign, bus_err}, {29'b0, e.mask});
      if (e.mask == EV_LOAD) chk("load_data", load_data, e.data);
    end else if (load_valid || misalign || bus_err) begin
      chk("unexpected_event", {29'b0, load_valid, misalign, bus_err}, 32'h0);
    end
  endtask

  task automatic do_load(input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
    req_valid = 1'b1; load_type = t; addr = a; kill = 1'b0;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = rd;
    sb.push_back('{EV_LOAD, exp, cyc + 3});
    #1 chk("accept_stall", {31'b0, stall}, 32'h1);
    tick();
    req_valid = 1'b0;
    #1 chk("req_high", {31'b0, mem_req}, 32'h1);
    chk("mem_addr", mem_addr, {a[31:2], 2'b00});
    chk("req_stall", {31'b0, stall}, 32'h1);
    tick();
    #1 chk("wait_req_low", {31'b0, mem_req}, 32'h0);
    chk("wait_stall", {31'b0, stall}, 32'h1);
    tick();
    #1 chk("done_stall", {31'b0, stall}, 32'h0);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    tick();
    chk("load_data_hold", load_data, exp);
    last_data = exp;
  endtask

  task automatic do_misalign(input logic [2:0] t, input logic [31:0] a);
    req_valid = 1'b1; load_type = t; addr = a; kill = 1'b0;
    sb.push_back('{EV_MIS, 32'h0, cyc + 1});
    #1 chk("mis_stall", {31'b0, stall}, 32'h0);
    chk("mis_req", {31'b0, mem_req}, 32'h0);
    tick();
    req_valid = 1'b0;
    #1 chk("mis_req_after", {31'b0, mem_req}, 32'h0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; load_type = 3'b000; addr = '0; kill = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_load_valid", {31'b0, load_valid}, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'h0);
    rst_n = 1'b1;
    tick();

    $display("[TB] extraction loads");
    do_load(3'b000, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80);
    do_load(3'b101, 32'h0000_2002, 32'h8001_7FFF, 32'h0000_8001);
    do_load(3'b001, 32'h0000_2000, 32'h8001_7FFF, 32'h0000_7FFF);
    do_load(3'b010, 32'h0000_2004, 32'hCAFE_F00D, 32'hCAFE_F00D);
    do_load(3'b001, 32'h0000_2002, 32'h8001_7FFF, 32'hFFFF_8001);

    $display("[TB] misaligned and illegal requests");
    do_misalign(3'b010, 32'h0000_3001);
    do_misalign(3'b011, 32'h0000_3000);
    do_misalign(3'b101, 32'h0000_3003);

    $display("[TB] delayed grant and response timeout");
    req_valid = 1'b1; load_type = 3'b010; addr = 32'h0000_4000; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    sb.push_back('{EV_BUS, 32'h0, cyc + 21});
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_gnt = 1'b1;
      #1 chk("to_req_high", {31'b0, mem_req}, 32'h1);
      chk("to_req_stall", {31'b0, stall}, 32'h1);
      tick();
    end
    mem_gnt = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1 chk("to_wait_stall", {31'b0, stall}, 32'h1);
      chk("to_wait_req", {31'b0, mem_req}, 32'h0);
      tick();
    end
    #1 chk("to_end_stall", {31'b0, stall}, 32'h0);
    tick();

    $display("[TB] kill in WAIT, response drained");
    req_valid = 1'b1; load_type = 3'b010; addr = 32'h0000_5000; mem_gnt = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    kill = 1'b1;
    tick();
    kill = 1'b0; mem_gnt = 1'b0;
    #1 chk("drain_stall", {31'b0, stall}, 32'h1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1 chk("drain_rvalid_stall", {31'b0, stall}, 32'h1);
    tick();
    mem_rvalid = 1'b0;
    #1 chk("drain_done_stall", {31'b0, stall}, 32'h0);
    chk("drain_data_kept", load_data, last_data);
    tick();

    $display("[TB] kill together with rvalid");
    req_valid = 1'b1; load_type = 3'b010; addr = 32'h0000_5004; mem_gnt = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    kill = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    kill = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b0;
    #1 chk("killrv_stall", {31'b0, stall}, 32'h0);
    chk("killrv_data_kept", load_data, last_data);
    tick();

    $display("[TB] kill in REQ beats grant");
    req_valid = 1'b1; load_type = 3'b000; addr = 32'h0000_5001; mem_gnt = 1'b1;
    tick();
    req_valid = 1'b0; kill = 1'b1;
    tick();
    kill = 1'b0; mem_gnt = 1'b0;
    #1 chk("killreq_stall", {31'b0, stall}, 32'h0);
    chk("killreq_req", {31'b0, mem_req}, 32'h0);
    tick();

    $display("[TB] reset in WAIT with stale response");
    req_valid = 1'b1; load_type = 3'b010; addr = 32'h0000_5008; mem_gnt = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0; mem_gnt = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_data", load_data, 32'h0);
    #1 chk("mid_rst_stall", {31'b0, stall}, 32'h0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    #1 chk("stale_stall", {31'b0, stall}, 32'h0);
    chk("stale_data", load_data, 32'h0);
    last_data = '0;
    do_load(3'b100, 32'h0000_6001, 32'h0000_AB00, 32'h0000_00AB);

    tick(); tick();
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
